// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: one CHUNK-bit ripple slice per stage, valid/ready
// handshake with per-stage backpressure, carry-out and signed-overflow flags.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic [STAGES-1:0]            r_valid;
  logic [STAGES-1:0][WIDTH-1:0] r_a;
  logic [STAGES-1:0][WIDTH-1:0] r_b;
  logic [STAGES-1:0][WIDTH-1:0] r_sum;
  logic [STAGES-1:0]            r_carry;
  logic                         r_c_msb;

  logic [STAGES-1:0][WIDTH-1:0] w_src_a;
  logic [STAGES-1:0][WIDTH-1:0] w_src_b;
  logic [STAGES-1:0][WIDTH-1:0] w_src_sum;
  logic [STAGES-1:0]            w_src_c;
  logic [STAGES-1:0]            w_src_v;
  logic [STAGES-1:0][CHUNK:0]   w_chunk;
  logic [STAGES-1:0][WIDTH-1:0] w_nxt_sum;
  logic [STAGES-1:0]            w_ready;
  logic                         w_c_msb;
  logic                         w_unused;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_src_a   = '0;
    w_src_b   = '0;
    w_src_sum = '0;
    w_src_c   = '0;
    w_src_v   = '0;
    w_chunk   = '0;
    w_nxt_sum = '0;
    w_ready   = '0;

    w_src_a[0]   = a;
    w_src_b[0]   = b;
    w_src_sum[0] = '0;
    w_src_c[0]   = c_in;
    w_src_v[0]   = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      w_src_a[s]   = r_a[s-1];
      w_src_b[s]   = r_b[s-1];
      w_src_sum[s] = r_sum[s-1];
      w_src_c[s]   = r_carry[s-1];
      w_src_v[s]   = r_valid[s-1];
    end

    for (int s = 0; s < STAGES; s++) begin
      w_chunk[s] = {1'b0, w_src_a[s][s*CHUNK +: CHUNK]}
                 + {1'b0, w_src_b[s][s*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, w_src_c[s]};
      w_nxt_sum[s] = w_src_sum[s];
      w_nxt_sum[s][s*CHUNK +: CHUNK] = w_chunk[s][CHUNK-1:0];
      // A stage may advance if any stage at or after it has a hole, or the consumer takes.
      w_ready[s] = out_ready;
      for (int k = s; k < STAGES; k++) begin
        if (!r_valid[k]) w_ready[s] = 1'b1;
      end
    end

    w_c_msb = w_src_a[LAST][WIDTH-1] ^ w_src_b[LAST][WIDTH-1] ^ w_nxt_sum[LAST][WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are cleared too, so outputs read zero under reset, not stale sums.
      r_valid <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= '0;
      r_c_msb <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let every stage sample its predecessor's pre-edge value.
      for (int s = 0; s < STAGES; s++) begin
        if (w_ready[s]) begin
          r_valid[s] <= w_src_v[s];
          if (w_src_v[s]) begin
            r_a[s]     <= w_src_a[s];
            r_b[s]     <= w_src_b[s];
            r_sum[s]   <= w_nxt_sum[s];
            r_carry[s] <= w_chunk[s][CHUNK];
          end
        end
      end
      if (w_ready[LAST] && w_src_v[LAST]) r_c_msb <= w_c_msb;
    end
  end

  // Operand bits already consumed (and the last stage's copy) are carried but never read.
  assign w_unused = ^{r_a, r_b};

  assign in_ready  = w_ready[0];
  assign out_valid = r_valid[LAST];
  assign sum       = r_sum[LAST];
  assign c_out     = r_carry[LAST];
  assign overflow  = r_c_msb ^ r_carry[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder: a 4-stage (CHUNK=8) and a
// 1-stage (CHUNK=32) instance driven with hand-computed vectors.
module tb_pipelined_adder;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        c_in;
  logic        out_valid, out_ready;
  logic [31:0] sum;
  logic        c_out, overflow;

  logic        in_valid1, in_ready1;
  logic        out_valid1, out_ready1;
  logic [31:0] sum1;
  logic        c_out1, overflow1;

  int total;
  int bad;
  int idx;
  int emitted;
  logic acc, em;

  logic [31:0] sa [16];
  logic [31:0] sb [16];
  logic        sc [16];
  logic [33:0] e;

  logic [31:0] ba  [6] = '{32'h00000001, 32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h0000FFFF, 32'h7FFFFFFF};
  logic [31:0] bb  [6] = '{32'h00000002, 32'hFFFFFFFF, 32'h11111111, 32'hFFFFFFFF, 32'h00000001, 32'h7FFFFFFF};
  logic        bc  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] bs  [6] = '{32'h00000003, 32'hFFFFFFFF, 32'h23456789, 32'h7FFFFFFF, 32'h00010001, 32'hFFFFFFFE};
  logic        bco [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        bov [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  pipelined_adder #(.WIDTH(32), .CHUNK(32)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .c_out(c_out1), .overflow(overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci);
    logic [32:0] t;
    t = {1'b0, x} + {1'b0, y} + {32'b0, ci};
    return {(x[31] == y[31]) && (t[31] != x[31]), t[32], t[31:0]};
  endfunction

  // One beat into both instances; checks latency 4 on u_dut and latency 1 on u_dut1.
  task automatic run_one(input logic [31:0] x, input logic [31:0] y, input logic ci,
                         input logic [31:0] es, input logic ec, input logic eo);
    a = x; b = y; c_in = ci;
    in_valid = 1'b1; in_valid1 = 1'b1; out_ready = 1'b1;
    check1("one_in_ready", in_ready, 1'b1);
    check1("one_in_ready1", in_ready1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; in_valid1 = 1'b0;
    check1("one1_valid", out_valid1, 1'b1);
    check("one1_sum", sum1, es);
    check1("one1_cout", c_out1, ec);
    check1("one1_ovf", overflow1, eo);
    check1("one_early_valid0", out_valid, 1'b0);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      check1("one_early_valid", out_valid, 1'b0);
    end
    @(negedge clk);
    check1("one_valid", out_valid, 1'b1);
    check("one_sum", sum, es);
    check1("one_cout", c_out, ec);
    check1("one_ovf", overflow, eo);
    check1("one1_drained", out_valid1, 1'b0);
    @(negedge clk);
    check1("one_drained", out_valid, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
    out_ready = 1'b1; out_ready1 = 1'b1;
    a = '0; b = '0; c_in = 1'b0;

    // Asynchronous reset asserted mid-cycle, observed before any clock edge.
    #2 rst = 1'b1;
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 32'h0);
    check1("rst_cout", c_out, 1'b0);
    check1("rst_ovf", overflow, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst1_out_valid", out_valid1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Carry ripple across every chunk, then signed-overflow cases.
    run_one(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_one(32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1);
    run_one(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);

    // Streaming: 16 back-to-back beats, results on consecutive cycles.
    for (int i = 0; i < 16; i++) begin
      sa[i] = $urandom;
      sb[i] = $urandom;
      sc[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 19; k++) begin
      if (k < 16) begin
        a = sa[k]; b = sb[k]; c_in = sc[k]; in_valid = 1'b1;
        check1("stream_in_ready", in_ready, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k >= 3) begin
        e = model(sa[k-3], sb[k-3], sc[k-3]);
        check1("stream_valid", out_valid, 1'b1);
        check("stream_sum", sum, e[31:0]);
        check1("stream_cout", c_out, e[32]);
        check1("stream_ovf", overflow, e[33]);
      end else begin
        check1("stream_fill", out_valid, 1'b0);
      end
    end
    @(negedge clk);
    check1("stream_drained", out_valid, 1'b0);

    // Backpressure: consumer stalled, only 4 beats fit.
    out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin a = ba[idx]; b = bb[idx]; c_in = bc[idx]; end
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) idx++;
    end
    check("bp_accepted", idx, 4);
    check1("bp_in_ready", in_ready, 1'b0);
    check1("bp_held_valid", out_valid, 1'b1);
    check("bp_held_sum", sum, bs[0]);
    check1("bp_held_cout", c_out, bco[0]);
    check1("bp_held_ovf", overflow, bov[0]);

    // Consumer toggles ready; every beat must emerge once, in order, stable while stalled.
    emitted = 0;
    for (int k = 0; k < 40 && emitted < 6; k++) begin
      out_ready = (k % 2 == 0);
      in_valid = (idx < 6);
      if (idx < 6) begin a = ba[idx]; b = bb[idx]; c_in = bc[idx]; end
      if (out_valid) begin
        check("bp_sum", sum, bs[emitted]);
        check1("bp_cout", c_out, bco[emitted]);
        check1("bp_ovf", overflow, bov[emitted]);
      end
      acc = in_valid && in_ready;
      em  = out_valid && out_ready;
      @(negedge clk);
      if (acc) idx++;
      if (em) emitted++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_emitted", emitted, 6);
    check("bp_all_accepted", idx, 6);
    @(negedge clk);
    check1("bp_no_dup", out_valid, 1'b0);

    // Reset with 3 beats in flight: none may emerge afterwards.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 32'h00000010 << k; b = 32'h00000020; c_in = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check1("mid_pre_valid", out_valid, 1'b1);
    check("mid_pre_sum", sum, 32'h00000030);
    #2 rst = 1'b1;
    #1;
    check1("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_sum", sum, 32'h0);
    check1("mid_rst_cout", c_out, 1'b0);
    check1("mid_rst_ovf", overflow, 1'b0);
    check1("mid_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check1("mid_discarded", out_valid, 1'b0);
    end
    run_one(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined WIDTH-bit binary adder with carry-in, carry-out and signed-overflow flag, built as STAGES ripple chunks of CHUNK bits each, one chunk per pipeline stage. It is the datapath-width successor to the single-bit full adder: the same a + b + c_in function, but registered, streamed through a valid/ready handshake with per-stage backpressure, and sized by parameter. It sits between an operand producer and a result consumer, and accepts one addition per cycle at full throughput.

## Interface
- WIDTH, 32, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits resolved per stage; 1 ≤ CHUNK ≤ WIDTH; STAGES = WIDTH/CHUNK (derived, not overridable).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- c_in  in  1  carry into bit 0.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  (a + b + c_in) mod 2^WIDTH.
- c_out  out  1  carry out of bit WIDTH-1.
- overflow  out  1  signed overflow: carry into MSB XOR c_out.

## Operation
- Beat transfer at input when in_valid & in_ready; at output when out_valid & out_ready.
- Stage s (1..STAGES) holds a valid bit, sum bits [s*CHUNK-1:0], the unprocessed upper bits of a and b, and the running carry.
- On acceptance, stage 1 loads chunk 0 = a[CHUNK-1:0] + b[CHUNK-1:0] + c_in, its carry, and a/b upper bits.
- Stage s+1 adds chunk s of the carried operands plus stage s carry and appends the result above the lower bits.
- The last stage also registers carry-into-MSB (for overflow) and c_out; it is the output register: sum, c_out, overflow, out_valid come directly from it.
- Per-stage advance: ready_STAGES = ~valid_STAGES | out_ready; ready_s = ~valid_s | ready_(s+1); in_ready = ready_1. Bubbles collapse: a stage with an empty successor advances even when out_ready is low.
- A stage that does not advance holds all its contents unchanged; a stage that passes data on and receives none clears its valid bit.
- Order is strictly preserved; no beat is dropped or duplicated.
- in_ready is combinational from the valid bits and out_ready; no combinational path from in_valid to in_ready or from in_valid/a/b to outputs.
- Reset (asynchronous, any time, including mid-stream): all valid bits 0, all data registers 0; in-flight beats are discarded. Outputs under reset: out_valid 0, sum 0, c_out 0, overflow 0; in_ready 1.
- Width rules: chunk adds are CHUNK+1 bits wide; sum is truncated to WIDTH; no saturation. c_out is meaningful for unsigned operands, overflow for signed ones.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (visible in the cycle following the STAGES-th capture), assuming no stall. With STAGES=1 the result is visible the cycle after acceptance.
- Throughput: one beat per cycle while out_ready stays high.
- Capacity: STAGES beats; with out_ready low, in_ready deasserts only once all stages are valid.
- Simultaneous accept and emit in a full pipeline with out_ready=1: in_ready=1, both transfers occur on the same edge.
- While out_valid & ~out_ready, sum/c_out/overflow are stable until the transfer.

## Test plan
- Reset: rst high mid-cycle (async) -> out_valid=0, sum=0, c_out=0, overflow=0, in_ready=1 immediately, without a clock edge.
- Carry ripple (WIDTH=32, CHUNK=8): a=0xFFFFFFFF, b=0x00000001, c_in=0, out_ready=1 -> out_valid exactly 4 cycles after accept, sum=0x00000000, c_out=1, overflow=0; repeat with CHUNK=32 -> same values at latency 1.
- Signed overflow: a=0x7FFFFFFF, b=0x00000000, c_in=1 -> sum=0x80000000, c_out=0, overflow=1; a=0x80000000, b=0x80000000 -> sum=0, c_out=1, overflow=1.
- Streaming: 16 back-to-back random beats, out_ready=1 -> 16 results on consecutive cycles, in order, each matching a+b+c_in mod 2^32.
- Backpressure/bubbles: out_ready=0, offer 6 beats -> exactly 4 accepted, in_ready=0 thereafter, output held stable; then out_ready toggles 1/0 each cycle -> all 6 beats emerge in order, no loss or duplicate.
- Reset mid-operation: 3 beats in flight, pulse rst for one cycle -> out_valid=0, none of the 3 ever emerge; the next accepted beat yields the correct result at normal latency.
